// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M execute unit with its own sequencing FSM.
// Accepts one MUL/DIV-class op, stalls the pipeline while it runs and reports the
// result with a single-cycle done pulse.
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-high reset
//   i_start, i_flush    op request from ID/EX, kill of the in-flight op
//   i_funct3            RV32M operation select
//   i_rs1_data/i_rs2_data operands a and b
//   i_rd_in             destination register of the op
//   o_stall             pipeline freeze request (combinational)
//   o_done              one-cycle completion pulse (registered)
//   o_result, o_rd_out  result and destination, held until the next done
module muldiv_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_in,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_out
);

  localparam int unsigned CW = (MUL_STAGES > XLEN) ? $clog2(MUL_STAGES) : $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;        // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0] r_b;        // multiplier, or divisor magnitude
  logic [XLEN-1:0] r_rem;      // partial remainder
  logic [1:0]      r_funct;    // low funct3 bits select variant within mul/div
  logic            r_neg_q;
  logic            r_neg_r;
  logic [4:0]      r_rd;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  // Acceptance and operand preprocessing
  logic            w_idle_like, w_accept, w_is_div, w_div_signed;
  logic            w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_special_res;

  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept     = w_idle_like & i_start & ~i_flush;
  assign w_is_div     = i_funct3[2];
  assign w_div_signed = ~i_funct3[0];
  assign w_a_neg      = w_div_signed & i_rs1_data[XLEN-1];
  assign w_b_neg      = w_div_signed & i_rs2_data[XLEN-1];
  assign w_a_abs      = w_a_neg ? -i_rs1_data : i_rs1_data;
  assign w_b_abs      = w_b_neg ? -i_rs2_data : i_rs2_data;
  assign w_div_zero   = (i_rs2_data == '0);
  assign w_div_ovf    = w_div_signed & (i_rs1_data == MIN_INT) & (i_rs2_data == '1);
  assign w_special    = w_div_zero | w_div_ovf;

  // Special divides resolve in the accepting cycle; funct3[1] selects remainder
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) w_special_res = i_funct3[1] ? i_rs1_data : '1;
    else            w_special_res = i_funct3[1] ? '0 : MIN_INT;
  end

  // Multiply: 64-bit product of sign/zero-extended operands (MULHU unsigned a, MULHSU/MULHU unsigned b)
  logic            w_mul_sa, w_mul_sb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_mul_res;

  assign w_mul_sa  = (r_funct != 2'b11) & r_a[XLEN-1];
  assign w_mul_sb  = ~r_funct[1] & r_b[XLEN-1];
  assign w_prod    = {{XLEN{w_mul_sa}}, r_a} * {{XLEN{w_mul_sb}}, r_b};
  assign w_mul_res = (r_funct == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Restoring divide step: shift in next dividend bit, subtract divisor if it fits
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge;

  assign w_shift = {r_rem, r_a[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_ge    = ~w_diff[XLEN];

  // Sign correction applied while in FIX
  logic [XLEN-1:0] w_fix_res;
  assign w_fix_res = r_funct[1] ? (r_neg_r ? -r_rem : r_rem)
                                : (r_neg_q ? -r_a   : r_a);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            if (!w_is_div)      w_next = ST_MUL;
            else if (w_special) w_next = ST_DONE;
            else                w_next = ST_DIV;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_MUL:  if (r_cnt == CW'(MUL_STAGES - 1)) w_next = ST_DONE;
        ST_DIV:  if (r_cnt == CW'(XLEN - 1))       w_next = ST_FIX;
        ST_FIX:  w_next = ST_DONE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Result source depends on which state leads into DONE
  logic [XLEN-1:0] w_res_next;
  logic [4:0]      w_rd_next;
  always_comb begin
    w_res_next = w_special_res;
    case (r_state)
      ST_MUL:  w_res_next = w_mul_res;
      ST_FIX:  w_res_next = w_fix_res;
      default: w_res_next = w_special_res;
    endcase
    w_rd_next = w_accept ? i_rd_in : r_rd;
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_funct  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rd     <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_funct <= i_funct3[1:0];
        r_rd    <= i_rd_in;
        r_rem   <= '0;
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_a     <= w_is_div ? w_a_abs : i_rs1_data;
        r_b     <= w_is_div ? w_b_abs : i_rs2_data;
      end else if (r_state == ST_MUL) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (r_state == ST_DIV) begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        r_a   <= {r_a[XLEN-2:0], w_ge};
      end else begin
        r_cnt <= '0;
      end

      r_done <= (w_next == ST_DONE);
      if (w_next == ST_DONE) begin
        r_result <= w_res_next;
        r_rd_out <= w_rd_next;
      end
    end
  end

  // Stall covers the accepting cycle and every busy state; dropped while in reset
  assign o_stall  = ~i_reset & (w_accept | (r_state == ST_MUL) |
                                (r_state == ST_DIV) | (r_state == ST_FIX));
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed ops, scoreboard queue checked by a monitor.
module tb_muldiv_sequencer;

  logic        clk, reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_in;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_sequencer #(.XLEN(32), .MUL_STAGES(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_flush(flush),
    .i_funct3(funct3), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_rd_in(rd_in),
    .o_stall(stall), .o_done(done), .o_result(result), .o_rd_out(rd_out)
  );

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                         F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done must match the oldest expected response
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got result %h rd %0d at cycle %0d, expected no done",
                 result, rd_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_rd"}, 32'(rd_out), 32'(e.rd));
        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    funct3 = f; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
  endtask

  task automatic push(input string name, input logic [31:0] res, input logic [4:0] rd,
                      input int at);
    exp_t e;
    e.name = name; e.res = res; e.rd = rd; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
    tick();
    tick();
  endtask

  // Issue one op from idle; latency counted from the accepting cycle
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] res, input int lat);
    tick();
    drive(f, a, b, rd);
    push(name, res, rd, cyc + lat);
    tick();
    start = 1'b0;
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, acc, n;
    reset = 1'b1; start = 1'b1; flush = 1'b0;
    funct3 = F_MUL; rs1 = 32'd1; rs2 = 32'd1; rd_in = 5'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // 1: MUL with stall profile
    tick();
    drive(F_MUL, 32'd7, 32'hFFFFFFFD, 5'd10);
    c0 = cyc;
    push("mul", 32'hFFFFFFEB, 5'd10, c0 + 2);
    #1 chk("mul_stall_c0", 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    #1 chk("mul_stall_c1", 32'(stall), 32'd1);
    tick();
    #1 chk("mul_stall_c2", 32'(stall), 32'd0);
    chk("mul_done_c2", 32'(done), 32'd1);
    drain("mul");

    // 2: high-half multiplies
    run_op("mulh",   F_MULH,   32'h80000000, 32'h80000000, 5'd11, 32'h40000000, 2);
    run_op("mulhu",  F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE, 2);
    run_op("mulhsu", F_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd13, 32'hFFFFFFFF, 2);

    // 3: normal divides
    run_op("div_neg", F_DIV,  32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFD, 34);
    run_op("rem_neg", F_REM,  32'hFFFFFFF9, 32'd2,        5'd15, 32'hFFFFFFFF, 34);
    run_op("divu",    F_DIVU, 32'd100,      32'd7,        5'd16, 32'd14,       34);
    run_op("remu",    F_REMU, 32'd100,      32'd7,        5'd17, 32'd2,        34);
    run_op("div_nd",  F_DIV,  32'd7,        32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, 34);
    run_op("rem_nd",  F_REM,  32'd7,        32'hFFFFFFFE, 5'd19, 32'd1,        34);

    // 4: special divides
    run_op("divu_z", F_DIVU, 32'd5,        32'd0,        5'd20, 32'hFFFFFFFF, 1);
    run_op("rem_z",  F_REM,  32'd5,        32'd0,        5'd21, 32'd5,        1);
    run_op("div_z",  F_DIV,  32'd5,        32'd0,        5'd22, 32'hFFFFFFFF, 1);
    run_op("div_ov", F_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd23, 32'h80000000, 1);
    run_op("rem_ov", F_REM,  32'h80000000, 32'hFFFFFFFF, 5'd24, 32'd0,        1);

    // 5: flush mid-divide, then a MUL right after
    tick();
    drive(F_DIV, 32'hFFFFFFF9, 32'd2, 5'd4);
    c0 = cyc;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 chk("flush_stall_c11", 32'(stall), 32'd0);
    chk("flush_cycle", 32'(cyc), 32'(c0 + 11));
    drive(F_MUL, 32'd6, 32'd7, 5'd5);
    push("post_flush_mul", 32'd42, 5'd5, cyc + 2);
    tick();
    start = 1'b0;
    drain("post_flush_mul");

    // 6: back-to-back MUL then DIV held through the done cycle, ignored mid-DIV start
    tick();
    drive(F_MUL, 32'd3, 32'd5, 5'd1);
    c0 = cyc;
    push("b2b_mul", 32'd15, 5'd1, c0 + 2);
    tick();
    drive(F_DIVU, 32'd100, 32'd7, 5'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 10);
    acc = cyc;
    chk("b2b_accept_cycle", 32'(acc), 32'(c0 + 2));
    chk("b2b_accept_stall", 32'(stall), 32'd1);
    tick();
    push("b2b_div", 32'd14, 5'd2, acc + 34);
    start = 1'b0;
    repeat (5) tick();
    drive(F_MUL, 32'd9, 32'd9, 5'd9);
    #1 chk("mid_div_stall", 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    drain("b2b_div");

    // 6: asynchronous reset in the middle of a divide
    tick();
    drive(F_DIVU, 32'd1000, 32'd3, 5'd3);
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_rd", 32'(rd_out), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    #1 chk("post_rst_stall", 32'(stall), 32'd0);
    repeat (40) tick();
    chk("post_rst_result", result, 32'd0);

    run_op("final_mul", F_MUL, 32'd100, 32'd100, 5'd31, 32'd10000, 2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
